// File: rtl/pio_edge_in.sv
// pio_edge_in: Avalon-MM input PIO with a 2-flop pin synchronizer, per-bit sticky edge capture and a level irq.
// Build option PIO_IN_IRQ_EN: when defined, IRQMASK and irq are present; otherwise IRQMASK reads 0 and irq is tied low.
module pio_edge_in #(
    parameter int               WIDTH     = 2,
    parameter int               EDGE_TYPE = 0,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [1:0]       address,
    input  logic             chipselect,
    input  logic             write_n,
    input  logic [WIDTH-1:0] writedata,
    input  logic [WIDTH-1:0] in_port,
    output logic [WIDTH-1:0] readdata,
    output logic             irq
);

    // Bus: read = chipselect & write_n, write = chipselect & ~write_n; never stalls,
    // readdata is loaded on the edge that ends the read cycle and held otherwise.
    logic rd_en;
    logic wr_en;
    assign rd_en = chipselect & write_n;
    assign wr_en = chipselect & ~write_n;

    logic [WIDTH-1:0] sync1;
    logic [WIDTH-1:0] sync2;
    logic [WIDTH-1:0] prev;
    logic [WIDTH-1:0] rise;
    logic [WIDTH-1:0] fall;
    logic [WIDTH-1:0] edge_hit;
    logic [WIDTH-1:0] edge_cap;
    logic [WIDTH-1:0] cap_clr;
    logic [WIDTH-1:0] irq_mask;
    logic [WIDTH-1:0] rd_mux;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync1 <= RESET_VAL;
            sync2 <= RESET_VAL;
            prev  <= RESET_VAL;
        end else begin
            sync1 <= in_port;
            sync2 <= sync1;
            prev  <= sync2;
        end
    end

    assign rise     = sync2 & ~prev;
    assign fall     = ~sync2 & prev;
    assign edge_hit = (EDGE_TYPE == 0) ? rise :
                      (EDGE_TYPE == 1) ? fall : (rise | fall);

    assign cap_clr = (wr_en && address == 2'd3) ? writedata : '0;

    // A new edge is OR-ed in after the W1C mask so a coincident clear never drops it.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            edge_cap <= '0;
        end else begin
            edge_cap <= (edge_cap & ~cap_clr) | edge_hit;
        end
    end

`ifdef PIO_IN_IRQ_EN
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            irq_mask <= '0;
        end else if (wr_en && address == 2'd2) begin
            irq_mask <= writedata;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            irq <= 1'b0;
        end else begin
            irq <= |(edge_cap & irq_mask);
        end
    end
`else
    assign irq_mask = '0;
    assign irq      = 1'b0;
`endif

    always_comb begin
        rd_mux = '0;
        case (address)
            2'd0:    rd_mux = sync2;
            2'd2:    rd_mux = irq_mask;
            2'd3:    rd_mux = edge_cap;
            default: rd_mux = '0;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            readdata <= '0;
        end else if (rd_en) begin
            readdata <= rd_mux;
        end
    end

endmodule

// File: tb/tb_pio_edge_in.sv
// Directed bench for pio_edge_in: rising, falling and any-edge instances share one bus and pin set.
module tb_pio_edge_in;

`ifdef PIO_IN_IRQ_EN
    localparam logic IRQ_EN = 1'b1;
`else
    localparam logic IRQ_EN = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic [1:0] address = 2'd0;
    logic       chipselect = 1'b0;
    logic       write_n = 1'b1;
    logic [1:0] writedata = 2'd0;
    logic [1:0] in_port = 2'd0;
    logic [1:0] rd0, rd1, rd2;
    logic       irq0, irq1, irq2;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    pio_edge_in #(.WIDTH(2), .EDGE_TYPE(0)) dut_rise (
        .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
        .write_n(write_n), .writedata(writedata), .in_port(in_port),
        .readdata(rd0), .irq(irq0));
    pio_edge_in #(.WIDTH(2), .EDGE_TYPE(1)) dut_fall (
        .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
        .write_n(write_n), .writedata(writedata), .in_port(in_port),
        .readdata(rd1), .irq(irq1));
    pio_edge_in #(.WIDTH(2), .EDGE_TYPE(2)) dut_any (
        .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
        .write_n(write_n), .writedata(writedata), .in_port(in_port),
        .readdata(rd2), .irq(irq2));

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Called at a negedge; drives one bus cycle and returns at the following negedge.
    task automatic bus_write(input logic [1:0] a, input logic [1:0] d);
        chipselect = 1'b1; write_n = 1'b0; address = a; writedata = d;
        @(negedge clk);
        chipselect = 1'b0; write_n = 1'b1;
    endtask

    task automatic read_chk(input string tag, input logic [1:0] a,
                            input logic [1:0] e0, input logic [1:0] e1, input logic [1:0] e2);
        chipselect = 1'b1; write_n = 1'b1; address = a;
        @(negedge clk);
        chipselect = 1'b0;
        check({tag, "/rise"}, 32'(rd0), 32'(e0));
        check({tag, "/fall"}, 32'(rd1), 32'(e1));
        check({tag, "/any"},  32'(rd2), 32'(e2));
    endtask

    task automatic irq_chk(input string tag, input logic e0, input logic e1, input logic e2);
        check({tag, "/irq_rise"}, 32'(irq0), 32'(e0));
        check({tag, "/irq_fall"}, 32'(irq1), 32'(e1));
        check({tag, "/irq_any"},  32'(irq2), 32'(e2));
    endtask

    task automatic settle();
        repeat (4) @(negedge clk);
    endtask

    initial begin
        logic [1:0] m01;
        logic [1:0] m11;
        m01 = IRQ_EN ? 2'b01 : 2'b00;
        m11 = IRQ_EN ? 2'b11 : 2'b00;

        // Reset held while pins toggle
        repeat (3) begin
            @(negedge clk);
            in_port = ~in_port;
        end
        check("rst_rd_rise", 32'(rd0), 0);
        check("rst_rd_any", 32'(rd2), 0);
        irq_chk("rst", 1'b0, 1'b0, 1'b0);
        in_port = 2'b00;
        @(negedge clk);
        reset_n = 1'b1;
        settle();
        read_chk("rst_cap", 2'd3, 2'b00, 2'b00, 2'b00);
        read_chk("rst_mask", 2'd2, 2'b00, 2'b00, 2'b00);
        read_chk("rst_a1", 2'd1, 2'b00, 2'b00, 2'b00);

        // Synchronizer latency
        in_port = 2'b10;
        @(negedge clk);
        read_chk("sync_t1", 2'd0, 2'b00, 2'b00, 2'b00);
        read_chk("sync_t2", 2'd0, 2'b10, 2'b10, 2'b10);
        settle();
        read_chk("cap_b1_rise", 2'd3, 2'b10, 2'b00, 2'b10);
        bus_write(2'd3, 2'b11);
        settle();
        read_chk("cap_clr", 2'd3, 2'b00, 2'b00, 2'b00);

        // Rising capture with irq
        bus_write(2'd2, 2'b01);
        read_chk("mask01", 2'd2, m01, m01, m01);
        irq_chk("mask_noirq", 1'b0, 1'b0, 1'b0);
        in_port = 2'b11;
        settle();
        read_chk("cap_b0_rise", 2'd3, 2'b01, 2'b00, 2'b01);
        irq_chk("irq_set", IRQ_EN, 1'b0, IRQ_EN);
        bus_write(2'd3, 2'b01);
        irq_chk("irq_lag", IRQ_EN, 1'b0, IRQ_EN);
        read_chk("cap_w1c", 2'd3, 2'b00, 2'b00, 2'b00);
        irq_chk("irq_clr", 1'b0, 1'b0, 1'b0);

        // Edge and W1C of bit0 on the same clock
        in_port = 2'b10;
        settle();
        read_chk("cap_b0_fall", 2'd3, 2'b00, 2'b01, 2'b01);
        irq_chk("irq_fall", 1'b0, IRQ_EN, IRQ_EN);
        in_port = 2'b11;
        @(negedge clk);
        @(negedge clk);
        bus_write(2'd3, 2'b01);
        read_chk("collide", 2'd3, 2'b01, 2'b00, 2'b01);
        bus_write(2'd3, 2'b11);
        settle();
        read_chk("collide_clr", 2'd3, 2'b00, 2'b00, 2'b00);

        // Bit1 pulse 1->0->1 with a clear in between
        in_port = 2'b01;
        settle();
        read_chk("pulse_fall", 2'd3, 2'b00, 2'b10, 2'b10);
        bus_write(2'd3, 2'b11);
        in_port = 2'b11;
        settle();
        read_chk("pulse_rise", 2'd3, 2'b10, 2'b00, 2'b10);
        bus_write(2'd3, 2'b11);
        settle();

        // Full mask; irq only when the mask register exists
        bus_write(2'd2, 2'b11);
        read_chk("mask11", 2'd2, m11, m11, m11);
        in_port = 2'b10;
        settle();
        read_chk("mask11_cap", 2'd3, 2'b00, 2'b01, 2'b01);
        irq_chk("mask11_irq", 1'b0, IRQ_EN, IRQ_EN);
        read_chk("data_10", 2'd0, 2'b10, 2'b10, 2'b10);
        read_chk("a1_zero", 2'd1, 2'b00, 2'b00, 2'b00);

        // Reset mid-operation with captures pending
        reset_n = 1'b0;
        #1;
        check("mid_rst_rd_fall", 32'(rd1), 0);
        irq_chk("mid_rst", 1'b0, 1'b0, 1'b0);
        in_port = 2'b00;
        @(negedge clk);
        reset_n = 1'b1;
        settle();
        read_chk("post_rst_cap", 2'd3, 2'b00, 2'b00, 2'b00);
        read_chk("post_rst_mask", 2'd2, 2'b00, 2'b00, 2'b00);
        in_port = 2'b01;
        settle();
        read_chk("post_rst_edge", 2'd3, 2'b01, 2'b00, 2'b01);
        irq_chk("post_rst_irq", 1'b0, 1'b0, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
